// File: rtl/binary_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : binary_decoder_pkg
// Brief   : Shared constants, stage-entry type and one-hot decode helper.
// Revision: 1.0 - initial release
// ============================================================================
package binary_decoder_pkg;

    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_N = 1 << MAX_IN_W;

    typedef struct packed {
        logic                enable;
        logic [MAX_IN_W-1:0] code;
    } stage_entry_t;

    // Result is {err, word}; only word bits below out_n are meaningful.
    function automatic logic [MAX_OUT_N:0] decode_onehot(
        input logic [MAX_IN_W-1:0] code,
        input logic                enable,
        input int                  out_n
    );
        logic [MAX_OUT_N:0] w_res;
        w_res = '0;
        if (enable) begin
            if (int'({24'd0, code}) >= out_n) begin
                w_res[MAX_OUT_N] = 1'b1;
            end else begin
                w_res[code] = 1'b1;
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : decoder_skid_buf
// Brief   : Two-entry valid/ready skid buffer with registered ready and an
//           idle value loaded into the output stage whenever it empties.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_skid_buf #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_s_full
);

    logic             r_o_valid;
    logic             r_s_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_o_data;
    logic [WIDTH-1:0] r_s_data;

    logic w_o_free;
    logic w_accept;
    logic w_s_valid_nxt;

    assign w_o_free = !r_o_valid || i_ready;
    assign w_accept = i_valid && r_in_ready;

    // A free output stage always drains the skid, so S can only fill on a stall.
    always_comb begin
        w_s_valid_nxt = r_s_valid;
        if (w_o_free) begin
            w_s_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_s_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b0;
            r_o_data   <= IDLE_VAL;
            r_s_data   <= IDLE_VAL;
        end else begin
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= !w_s_valid_nxt;
            if (w_o_free) begin
                if (r_s_valid) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= r_s_data;
                end else if (w_accept) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= i_data;
                end else begin
                    r_o_valid <= 1'b0;
                    r_o_data  <= IDLE_VAL;
                end
            end else if (w_accept) begin
                r_s_data <= i_data;
            end
        end
    end

    assign o_ready  = r_in_ready;
    assign o_valid  = r_o_valid;
    assign o_data   = r_o_data;
    assign o_s_full = r_s_valid;

endmodule
`default_nettype wire

// File: rtl/binary_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : binary_decoder_pipe
// Brief   : Pipelined IN_W-to-OUT_N one-hot decoder with valid/ready on both
//           sides. Define BINARY_DECODER_PIPE_FORMAL_EN to compile in SVA.
// Revision: 1.0 - initial release
// ============================================================================
module binary_decoder_pipe
    import binary_decoder_pkg::*;
#(
    parameter int IN_W       = 2,
    parameter int OUT_N      = 1 << IN_W,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_enable,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out_onehot,
    output logic             out_err
);

    localparam logic [OUT_N-1:0] c_INACTIVE = {OUT_N{ACTIVE_LOW != 0}};

    generate
        if (IN_W < 1 || IN_W > MAX_IN_W || OUT_N < 2 || OUT_N > (1 << IN_W)) begin : g_param_err
            $error("binary_decoder_pipe: illegal IN_W/OUT_N combination");
        end
    endgenerate

    stage_entry_t       w_entry;
    logic [MAX_OUT_N:0] w_dec;
    logic [OUT_N:0]     w_in_data;
    logic [OUT_N:0]     w_out_data;
    logic               w_s_full;
    logic               w_unused_dec;

    always_comb begin
        w_entry             = '0;
        w_entry.enable      = in_enable;
        w_entry.code[IN_W-1:0] = in_code;
    end

    // Decode and polarity are applied before storage so both stages hold final words.
    assign w_dec        = decode_onehot(w_entry.code, w_entry.enable, OUT_N);
    assign w_in_data    = {w_dec[MAX_OUT_N], w_dec[OUT_N-1:0] ^ c_INACTIVE};
    assign w_unused_dec = ^w_dec;

    decoder_skid_buf #(
        .WIDTH   (OUT_N + 1),
        .IDLE_VAL({1'b0, c_INACTIVE})
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data),
        .o_s_full(w_s_full)
    );

    assign out_err    = w_out_data[OUT_N];
    assign out_onehot = w_out_data[OUT_N-1:0];

`ifdef BINARY_DECODER_PIPE_FORMAL_EN
    logic [1:0] w_occ;
    assign w_occ = {1'b0, out_valid} + {1'b0, w_s_full};

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $countones(out_onehot ^ c_INACTIVE) <= 1);
    a_err_inactive: assert property (@(posedge clk) disable iff (rst)
        out_err |-> (out_onehot == c_INACTIVE));
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_onehot) && $stable(out_err)));
    a_no_accept: assert property (@(posedge clk) disable iff (rst)
        !in_ready |=> (w_occ <= $past(w_occ)));
    a_occ: assert property (@(posedge clk) disable iff (rst) w_occ <= 2'd2);

    c_s_full: cover property (@(posedge clk) disable iff (rst) w_s_full);
    c_err:    cover property (@(posedge clk) disable iff (rst) out_valid && out_err);
    c_b2b:    cover property (@(posedge clk) disable iff (rst)
        (out_valid && out_ready) ##1 (out_valid && out_ready));
`endif

endmodule
`default_nettype wire

// File: tb/tb_binary_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_binary_decoder_pipe
// Brief   : Directed self-checking bench over three decoder configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_binary_decoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_in_valid = 1'b0, a_in_enable = 1'b0, a_out_ready = 1'b1;
    logic [1:0] a_in_code = '0;
    logic       a_in_ready, a_out_valid, a_out_err;
    logic [3:0] a_onehot;

    logic       b_in_valid = 1'b0, b_in_enable = 1'b0, b_out_ready = 1'b1;
    logic [2:0] b_in_code = '0;
    logic       b_in_ready, b_out_valid, b_out_err;
    logic [4:0] b_onehot;

    logic       c_in_valid = 1'b0, c_in_enable = 1'b0, c_out_ready = 1'b1;
    logic [1:0] c_in_code = '0;
    logic       c_in_ready, c_out_valid, c_out_err;
    logic [3:0] c_onehot;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    binary_decoder_pipe #(.IN_W(2), .OUT_N(4), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_enable(a_in_enable), .in_code(a_in_code), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_onehot(a_onehot), .out_err(a_out_err)
    );

    binary_decoder_pipe #(.IN_W(3), .OUT_N(5), .ACTIVE_LOW(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_enable(b_in_enable), .in_code(b_in_code), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_onehot(b_onehot), .out_err(b_out_err)
    );

    binary_decoder_pipe #(.IN_W(2), .OUT_N(4), .ACTIVE_LOW(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_enable(c_in_enable), .in_code(c_in_code), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_onehot(c_onehot), .out_err(c_out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_a_in_ready", 32'(a_in_ready), 32'h0);
            check("rst_a_valid",    32'(a_out_valid), 32'h0);
            check("rst_a_onehot",   32'(a_onehot), 32'h0);
            check("rst_a_err",      32'(a_out_err), 32'h0);
            check("rst_b_onehot",   32'(b_onehot), 32'h0);
            check("rst_c_onehot",   32'(c_onehot), 32'hF);
            check("rst_c_in_ready", 32'(c_in_ready), 32'h0);
        end
        rst = 1'b0;
        step();
        check("post_rst_a_in_ready", 32'(a_in_ready), 32'h1);
        check("post_rst_a_valid",    32'(a_out_valid), 32'h0);
        check("post_rst_b_in_ready", 32'(b_in_ready), 32'h1);
        check("post_rst_c_in_ready", 32'(c_in_ready), 32'h1);

        // Back-to-back stream of codes 0..3
        a_in_valid = 1'b1; a_in_enable = 1'b1; a_in_code = 2'd0;
        step();
        check("b2b0_valid",  32'(a_out_valid), 32'h1);
        check("b2b0_onehot", 32'(a_onehot), 32'h1);
        a_in_code = 2'd1;
        step();
        check("b2b1_onehot", 32'(a_onehot), 32'h2);
        check("b2b1_ready",  32'(a_in_ready), 32'h1);
        a_in_code = 2'd2;
        step();
        check("b2b2_onehot", 32'(a_onehot), 32'h4);
        a_in_code = 2'd3;
        step();
        check("b2b3_onehot", 32'(a_onehot), 32'h8);
        check("b2b3_err",    32'(a_out_err), 32'h0);
        a_in_valid = 1'b0;
        step();
        check("idle_valid",  32'(a_out_valid), 32'h0);
        check("idle_onehot", 32'(a_onehot), 32'h0);

        // Enable low decodes to nothing
        a_in_valid = 1'b1; a_in_enable = 1'b0; a_in_code = 2'd2;
        step();
        check("en0_valid",  32'(a_out_valid), 32'h1);
        check("en0_onehot", 32'(a_onehot), 32'h0);
        check("en0_err",    32'(a_out_err), 32'h0);
        a_in_valid = 1'b0; a_in_enable = 1'b1;
        step();

        // Stall: fill both stages, then drain
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_code = 2'd1;
        step();
        check("stall1_onehot", 32'(a_onehot), 32'h2);
        check("stall1_ready",  32'(a_in_ready), 32'h1);
        a_in_code = 2'd3;
        step();
        check("stall2_onehot", 32'(a_onehot), 32'h2);
        check("stall2_ready",  32'(a_in_ready), 32'h0);
        a_in_code = 2'd0;
        step();
        check("stall3_onehot", 32'(a_onehot), 32'h2);
        check("stall3_valid",  32'(a_out_valid), 32'h1);
        check("stall3_ready",  32'(a_in_ready), 32'h0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        check("drain1_valid",  32'(a_out_valid), 32'h1);
        check("drain1_onehot", 32'(a_onehot), 32'h8);
        check("drain1_ready",  32'(a_in_ready), 32'h1);
        step();
        check("drain2_valid",  32'(a_out_valid), 32'h0);
        check("drain2_onehot", 32'(a_onehot), 32'h0);

        // Reset mid-operation discards both buffered beats
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_code = 2'd2;
        step();
        a_in_code = 2'd1;
        step();
        check("mid_full_ready", 32'(a_in_ready), 32'h0);
        a_in_valid = 1'b0; rst = 1'b1;
        step();
        check("mid_rst_valid",  32'(a_out_valid), 32'h0);
        check("mid_rst_onehot", 32'(a_onehot), 32'h0);
        check("mid_rst_ready",  32'(a_in_ready), 32'h0);
        rst = 1'b0; a_out_ready = 1'b1;
        step();
        check("mid_post_ready", 32'(a_in_ready), 32'h1);
        check("mid_post_valid", 32'(a_out_valid), 32'h0);
        step();
        check("mid_post2_valid", 32'(a_out_valid), 32'h0);

        // OUT_N=5 out-of-range and top-of-range codes
        b_in_valid = 1'b1; b_in_enable = 1'b1; b_in_code = 3'd6;
        step();
        check("b6_valid",  32'(b_out_valid), 32'h1);
        check("b6_onehot", 32'(b_onehot), 32'h0);
        check("b6_err",    32'(b_out_err), 32'h1);
        b_in_code = 3'd4;
        step();
        check("b4_onehot", 32'(b_onehot), 32'h10);
        check("b4_err",    32'(b_out_err), 32'h0);
        b_in_code = 3'd5;
        step();
        check("b5_onehot", 32'(b_onehot), 32'h0);
        check("b5_err",    32'(b_out_err), 32'h1);
        b_in_valid = 1'b0;
        step();
        check("b_idle_valid", 32'(b_out_valid), 32'h0);
        check("b_idle_err",   32'(b_out_err), 32'h0);

        // Active-low polarity
        c_in_valid = 1'b1; c_in_enable = 1'b1; c_in_code = 2'd1;
        step();
        check("c1_valid",  32'(c_out_valid), 32'h1);
        check("c1_onehot", 32'(c_onehot), 32'hD);
        c_in_enable = 1'b0;
        step();
        check("c_en0_onehot", 32'(c_onehot), 32'hF);
        c_in_valid = 1'b0;
        step();
        check("c_idle_valid",  32'(c_out_valid), 32'h0);
        check("c_idle_onehot", 32'(c_onehot), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
